// File: rtl/active_trigger_host_end_pkg.sv
// Shared uc bus field layout and transmit FSM encoding for the trigger
// channel host endpoint.
package active_trigger_host_end_pkg;

  // uc bus trigger field positions
  localparam int UC_TRIG_CMD_BIT  = 8;
  localparam int UC_TRIG_BYTE_LSB = 0;
  localparam int UC_TRIG_BYTE_W   = 8;
  localparam int UC_IN_W          = 32;
  localparam int UC_OUT_W         = 30;

  // Transmit FSM encoding
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_DRIVE = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_e;

  // Larger of two integers, used to size the shared hold/gap counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/active_trigger_host_tx.sv
// Host-to-device trigger transmitter: drives a latched trigger byte onto the
// device uc_in word for HOLD_CYCLES cycles, then forces GAP_CYCLES idle
// cycles before another request can be accepted.
//
// Handshake: host_trig_req is sampled only while idle (busy = 0); a request
// with a non-zero byte is accepted on that edge, busy rises on the next
// cycle and stays high through DRIVE and GAP; host_trig_done pulses for one
// cycle once the gap has elapsed. Requests while busy, or with byte 0, are
// dropped, never queued.
module active_trigger_host_tx
  import active_trigger_host_end_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                      uc_clk,
  input  logic                      uc_reset,
  input  logic                      host_trig_req,
  input  logic [UC_TRIG_BYTE_W-1:0] host_trig_byte,
  output logic [UC_IN_W-1:0]        dev_uc_in,
  output logic                      host_trig_busy,
  output logic                      host_trig_done,
  output tx_state_e                 tx_state
);

  // One counter serves both phases, so it is sized for the longer of the two
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  tx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [UC_TRIG_BYTE_W-1:0] byte_q, byte_d;
  logic                      done_q, done_d;

  // State, counter, latched byte and done pulse registers
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept in IDLE, count down HOLD then GAP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (host_trig_req && (host_trig_byte != '0)) begin
          byte_d  = host_trig_byte;
          cnt_d   = HOLD_LOAD;
          state_d = TX_DRIVE;
        end
      end
      TX_DRIVE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = TX_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TX_GAP: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // uc_in decoded only from registers; bits above the trigger field stay 0
  always_comb begin
    dev_uc_in = '0;
    if (state_q == TX_DRIVE) begin
      dev_uc_in[UC_TRIG_CMD_BIT]                        = 1'b1;
      dev_uc_in[UC_TRIG_BYTE_LSB +: UC_TRIG_BYTE_W]     = byte_q;
    end
  end

  assign host_trig_busy = (state_q != TX_IDLE);
  assign host_trig_done = done_q;
  assign tx_state       = state_q;

endmodule

// File: rtl/active_trigger_host_end.sv
// Host-side endpoint of the uc bus trigger channel. Captures device trigger
// commands into sticky write-1-to-clear pending/overrun flags and sends host
// trigger commands through the transmit sub-module.
module active_trigger_host_end
  import active_trigger_host_end_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                      uc_clk,
  input  logic                      uc_reset,
  input  logic [UC_OUT_W-1:0]       dev_uc_out,
  output logic [UC_IN_W-1:0]        dev_uc_in,
  input  logic                      host_trig_req,
  input  logic [UC_TRIG_BYTE_W-1:0] host_trig_byte,
  output logic                      host_trig_busy,
  output logic                      host_trig_done,
  output logic [UC_TRIG_BYTE_W-1:0] trig_pending,
  input  logic [UC_TRIG_BYTE_W-1:0] trig_clear,
  output logic                      trig_event,
  output logic [UC_TRIG_BYTE_W-1:0] trig_overrun
);

  logic                      cmd_prev;
  logic                      capture;
  logic [UC_TRIG_BYTE_W-1:0] rx_byte;
  logic [UC_TRIG_BYTE_W-1:0] captured_bits;
  logic [UC_TRIG_BYTE_W-1:0] pend_q, pend_d;
  logic [UC_TRIG_BYTE_W-1:0] ovr_q, ovr_d;
  logic                      event_q;
  tx_state_e                 tx_state;
  logic                      unused_bits;

  // Upper uc_out bits carry other channels; tx state is a debug tap
  assign unused_bits = ^{dev_uc_out[UC_OUT_W-1:UC_TRIG_CMD_BIT+1], tx_state};

  // A command is taken once, on the rising edge of the command bit
  assign capture = dev_uc_out[UC_TRIG_CMD_BIT] & ~cmd_prev;
  assign rx_byte = dev_uc_out[UC_TRIG_BYTE_LSB +: UC_TRIG_BYTE_W];

  // Sticky flag update: clear first, then OR in new bits so set beats clear
  always_comb begin
    captured_bits = capture ? rx_byte : '0;
    pend_d        = (pend_q & ~trig_clear) | captured_bits;
    ovr_d         = (ovr_q & ~trig_clear) | (pend_q & captured_bits & ~trig_clear);
  end

  // Receive-side registers
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      cmd_prev <= 1'b0;
      pend_q   <= '0;
      ovr_q    <= '0;
      event_q  <= 1'b0;
    end else begin
      cmd_prev <= dev_uc_out[UC_TRIG_CMD_BIT];
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      event_q  <= capture;
    end
  end

  assign trig_pending = pend_q;
  assign trig_overrun = ovr_q;
  assign trig_event   = event_q;

  active_trigger_host_tx #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_tx (
    .uc_clk         (uc_clk),
    .uc_reset       (uc_reset),
    .host_trig_req  (host_trig_req),
    .host_trig_byte (host_trig_byte),
    .dev_uc_in      (dev_uc_in),
    .host_trig_busy (host_trig_busy),
    .host_trig_done (host_trig_done),
    .tx_state       (tx_state)
  );

endmodule

// File: tb/tb_active_trigger_host_end.sv
// Directed bench for the trigger channel host endpoint (default parameters:
// HOLD_CYCLES = 4, GAP_CYCLES = 2).
module tb_active_trigger_host_end;

  logic        uc_clk;
  logic        uc_reset;
  logic [29:0] dev_uc_out;
  logic [31:0] dev_uc_in;
  logic        host_trig_req;
  logic [7:0]  host_trig_byte;
  logic        host_trig_busy;
  logic        host_trig_done;
  logic [7:0]  trig_pending;
  logic [7:0]  trig_clear;
  logic        trig_event;
  logic [7:0]  trig_overrun;

  int checks = 0;
  int errors = 0;
  int ev_count = 0;

  active_trigger_host_end dut (
    .uc_clk         (uc_clk),
    .uc_reset       (uc_reset),
    .dev_uc_out     (dev_uc_out),
    .dev_uc_in      (dev_uc_in),
    .host_trig_req  (host_trig_req),
    .host_trig_byte (host_trig_byte),
    .host_trig_busy (host_trig_busy),
    .host_trig_done (host_trig_done),
    .trig_pending   (trig_pending),
    .trig_clear     (trig_clear),
    .trig_event     (trig_event),
    .trig_overrun   (trig_overrun)
  );

  // Clock
  initial begin
    uc_clk = 1'b0;
    forever #5 uc_clk = ~uc_clk;
  end

  // trig_event pulse counter, sampled mid-cycle
  always @(negedge uc_clk) begin
    if (trig_event === 1'b1) ev_count++;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next active edge
  task automatic step();
    @(posedge uc_clk);
    #1;
  endtask

  task automatic test_reset();
    uc_reset       = 1'b0;
    dev_uc_out     = 30'h1FF;
    host_trig_req  = 1'b0;
    host_trig_byte = 8'h00;
    trig_clear     = 8'h00;
    repeat (5) step();
    checks++; if (dev_uc_in !== 32'h0) begin errors++; $display("FAIL reset_uc_in: got %h expected %h", dev_uc_in, 32'h0); end
    checks++; if (host_trig_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", host_trig_busy); end
    checks++; if (host_trig_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", host_trig_done); end
    checks++; if (trig_pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h expected 00", trig_pending); end
    checks++; if (trig_event !== 1'b0) begin errors++; $display("FAIL reset_event: got %b expected 0", trig_event); end
    checks++; if (trig_overrun !== 8'h00) begin errors++; $display("FAIL reset_overrun: got %h expected 00", trig_overrun); end
    ev_count = 0;
    uc_reset = 1'b1;
    step();
    checks++; if (trig_pending !== 8'hFF) begin errors++; $display("FAIL release_pending: got %h expected ff", trig_pending); end
    checks++; if (trig_event !== 1'b1) begin errors++; $display("FAIL release_event: got %b expected 1", trig_event); end
    checks++; if (dev_uc_in !== 32'h0) begin errors++; $display("FAIL release_uc_in: got %h expected %h", dev_uc_in, 32'h0); end
    repeat (3) step();
    checks++; if (ev_count !== 1) begin errors++; $display("FAIL release_event_count: got %0d expected 1", ev_count); end
    dev_uc_out = 30'h0;
    trig_clear = 8'hFF;
    step();
    trig_clear = 8'h00;
    checks++; if (trig_pending !== 8'h00) begin errors++; $display("FAIL clear_all_pending: got %h expected 00", trig_pending); end
  endtask

  task automatic test_rx_sticky();
    ev_count   = 0;
    dev_uc_out = 30'h105;
    repeat (4) step();
    dev_uc_out = 30'h0;
    step();
    dev_uc_out = 30'h104;
    repeat (2) step();
    dev_uc_out = 30'h0;
    repeat (2) step();
    checks++; if (ev_count !== 2) begin errors++; $display("FAIL sticky_event_count: got %0d expected 2", ev_count); end
    checks++; if (trig_pending !== 8'h05) begin errors++; $display("FAIL sticky_pending: got %h expected 05", trig_pending); end
    checks++; if (trig_overrun !== 8'h04) begin errors++; $display("FAIL sticky_overrun: got %h expected 04", trig_overrun); end
    trig_clear = 8'h01;
    step();
    trig_clear = 8'h00;
    checks++; if (trig_pending !== 8'h04) begin errors++; $display("FAIL clear01_pending: got %h expected 04", trig_pending); end
    checks++; if (trig_overrun !== 8'h04) begin errors++; $display("FAIL clear01_overrun: got %h expected 04", trig_overrun); end
    trig_clear = 8'hFF;
    step();
    trig_clear = 8'h00;
    checks++; if ({trig_pending, trig_overrun} !== 16'h0000) begin errors++; $display("FAIL clearff_flags: got %h expected 0000", {trig_pending, trig_overrun}); end
  endtask

  task automatic test_set_beats_clear();
    dev_uc_out = 30'h180;
    step();
    dev_uc_out = 30'h0;
    step();
    checks++; if (trig_pending !== 8'h80) begin errors++; $display("FAIL sbc_pre_pending: got %h expected 80", trig_pending); end
    dev_uc_out = 30'h180;
    trig_clear = 8'h80;
    step();
    dev_uc_out = 30'h0;
    trig_clear = 8'h00;
    checks++; if (trig_pending !== 8'h80) begin errors++; $display("FAIL sbc_pending: got %h expected 80", trig_pending); end
    checks++; if (trig_overrun !== 8'h00) begin errors++; $display("FAIL sbc_overrun: got %h expected 00", trig_overrun); end
    step();
    ev_count   = 0;
    dev_uc_out = 30'h100;
    step();
    dev_uc_out = 30'h0;
    checks++; if (trig_event !== 1'b1) begin errors++; $display("FAIL zero_byte_event: got %b expected 1", trig_event); end
    step();
    checks++; if (trig_pending !== 8'h80) begin errors++; $display("FAIL zero_byte_pending: got %h expected 80", trig_pending); end
    checks++; if (ev_count !== 1) begin errors++; $display("FAIL zero_byte_event_count: got %0d expected 1", ev_count); end
    trig_clear = 8'hFF;
    step();
    trig_clear = 8'h00;
  endtask

  task automatic test_tx_nominal();
    logic [31:0] exp_in;
    logic        exp_busy;
    logic        exp_done;
    host_trig_byte = 8'hA3;
    host_trig_req  = 1'b1;
    #1;
    checks++; if (dev_uc_in !== 32'h0) begin errors++; $display("FAIL tx_no_comb_path: got %h expected %h", dev_uc_in, 32'h0); end
    step();
    host_trig_req  = 1'b0;
    host_trig_byte = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      exp_in   = (c <= 4) ? 32'h1A3 : 32'h0;
      exp_busy = (c <= 6);
      exp_done = (c == 7);
      checks++; if (dev_uc_in !== exp_in) begin errors++; $display("FAIL tx_nom_uc_in[%0d]: got %h expected %h", c, dev_uc_in, exp_in); end
      checks++; if (host_trig_busy !== exp_busy) begin errors++; $display("FAIL tx_nom_busy[%0d]: got %b expected %b", c, host_trig_busy, exp_busy); end
      checks++; if (host_trig_done !== exp_done) begin errors++; $display("FAIL tx_nom_done[%0d]: got %b expected %b", c, host_trig_done, exp_done); end
      step();
    end
  endtask

  task automatic test_tx_rejects();
    int drive_cnt;
    int bad_cnt;
    int done_cnt;
    int busy_cnt;
    host_trig_byte = 8'h00;
    host_trig_req  = 1'b1;
    step();
    host_trig_req  = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++; if ({dev_uc_in, host_trig_busy, host_trig_done} !== 34'h0) begin errors++; $display("FAIL tx_zero_idle[%0d]: got uc_in=%h busy=%b done=%b expected all 0", c, dev_uc_in, host_trig_busy, host_trig_done); end
      step();
    end
    drive_cnt = 0; bad_cnt = 0; done_cnt = 0; busy_cnt = 0;
    host_trig_byte = 8'h5C;
    host_trig_req  = 1'b1;
    step();
    host_trig_req  = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (dev_uc_in === 32'h15C) drive_cnt++;
      else if (dev_uc_in !== 32'h0) bad_cnt++;
      if (host_trig_done === 1'b1) done_cnt++;
      if (host_trig_busy === 1'b1) busy_cnt++;
      if (c == 2) begin host_trig_req = 1'b1; host_trig_byte = 8'h11; end
      if (c == 4) begin host_trig_req = 1'b0; host_trig_byte = 8'h00; end
      step();
    end
    checks++; if (drive_cnt !== 4) begin errors++; $display("FAIL tx_busy_drive_cycles: got %0d expected 4", drive_cnt); end
    checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL tx_busy_other_byte: got %0d cycles expected 0", bad_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL tx_busy_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL tx_busy_cycles: got %0d expected 6", busy_cnt); end
  endtask

  task automatic test_reset_mid_drive();
    int drive_cnt;
    int done_cnt;
    int busy_cnt;
    int bad_cnt;
    host_trig_byte = 8'h3C;
    host_trig_req  = 1'b1;
    step();
    host_trig_req  = 1'b0;
    step();
    checks++; if (dev_uc_in !== 32'h13C) begin errors++; $display("FAIL mid_drive_pre: got %h expected %h", dev_uc_in, 32'h13C); end
    uc_reset = 1'b0;
    #1;
    checks++; if (dev_uc_in !== 32'h0) begin errors++; $display("FAIL mid_reset_uc_in: got %h expected %h", dev_uc_in, 32'h0); end
    checks++; if (host_trig_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", host_trig_busy); end
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (host_trig_done === 1'b1) done_cnt++;
    end
    uc_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (host_trig_done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_reset_done: got %0d pulses expected 0", done_cnt); end
    drive_cnt = 0; bad_cnt = 0; done_cnt = 0; busy_cnt = 0;
    host_trig_byte = 8'h42;
    host_trig_req  = 1'b1;
    step();
    host_trig_req  = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (dev_uc_in === 32'h142) drive_cnt++;
      else if (dev_uc_in !== 32'h0) bad_cnt++;
      if (host_trig_done === 1'b1) done_cnt++;
      if (host_trig_busy === 1'b1) busy_cnt++;
      step();
    end
    checks++; if (drive_cnt !== 4) begin errors++; $display("FAIL post_reset_drive_cycles: got %0d expected 4", drive_cnt); end
    checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL post_reset_other_value: got %0d cycles expected 0", bad_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL post_reset_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL post_reset_busy_cycles: got %0d expected 6", busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_rx_sticky();
    test_set_beats_clear();
    test_tx_nominal();
    test_tx_rejects();
    test_reset_mid_drive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/active_trigger_host_end.md
Name: active_trigger_host_end

Overview:
- Host-side endpoint of the 8-bit trigger channel carried on the uc bus.
- Receives device-to-host trigger commands from the device's uc_out word (bit 8 = trigger command, bits 7:0 = trigger byte) and accumulates them into sticky, write-1-to-clear pending flags.
- Drives host-to-device trigger commands onto the device's uc_in word as fixed-length pulses under a req/busy/done handshake.
- Used as the host model in simulation and as the host-side bridge in FPGA-to-FPGA builds.

Parameters:
HOLD_CYCLES, 4, cycles uc_in[8] and the trigger byte are held per host-to-device command (min 1).
GAP_CYCLES, 2, idle cycles forced after each command before the next is accepted (min 1).

Ports:
uc_clk  input  1  single block clock
uc_reset  input  1  reset, asynchronous, active-low
dev_uc_out  input  30  device uc_out word; only bits 8:0 used, others ignored
dev_uc_in  output  32  device uc_in word; bit 8 = trigger command, 7:0 = trigger byte, 31:9 tied 0
host_trig_req  input  1  request to send host_trig_byte to device
host_trig_byte  input  8  trigger bits to send
host_trig_busy  output  1  transmitter in DRIVE or GAP
host_trig_done  output  1  one-cycle pulse when a command completes
trig_pending  output  8  sticky received trigger bits
trig_clear  input  8  write-1-to-clear mask for trig_pending and trig_overrun
trig_event  output  1  one-cycle pulse after each captured device command
trig_overrun  output  8  sticky: a bit was received again while still pending

Behaviour:
Reset (uc_reset low, asynchronous, any time including mid-command):
- All outputs, registers and counters go to 0; FSM goes to IDLE.
- dev_uc_in = 0 during reset and on the first clock after release.

Receive path:
- Register cmd_prev <= dev_uc_out[8] every cycle.
- Capture occurs on an edge where dev_uc_out[8]=1 and cmd_prev=0 (rising edge). A command held for multiple cycles is captured exactly once.
- On capture at edge N:
  - trig_pending <= (trig_pending & ~trig_clear) | byte
  - trig_overrun <= (trig_overrun & ~trig_clear) | (trig_pending & byte & ~trig_clear)
  - trig_event = 1 for the cycle following edge N.
- Set beats clear: a bit present in both byte and trig_clear at the same edge ends up 1.
- Capture with byte = 0: trig_event still pulses; pending is unchanged apart from the clear.
- Without capture: only the clear applies.
- A falling then rising dev_uc_out[8] with a single low cycle between them is a second, separate capture.

Transmit FSM (states IDLE, DRIVE, GAP):
- IDLE:
  - dev_uc_in = 0, busy = 0.
  - If host_trig_req=1 and host_trig_byte != 0: latch the byte, cnt <= HOLD_CYCLES-1, go to DRIVE.
  - A request with byte 0 is ignored: no state change, no done pulse.
- DRIVE:
  - dev_uc_in[8] = 1, dev_uc_in[7:0] = latched byte, busy = 1.
  - If cnt==0: cnt <= GAP_CYCLES-1, go to GAP; else decrement cnt.
  - The command is visible for exactly HOLD_CYCLES cycles, starting the cycle after req is sampled.
- GAP:
  - dev_uc_in = 0, busy = 1.
  - If cnt==0: host_trig_done = 1 for one cycle, go to IDLE; else decrement cnt.
- host_trig_req while busy is ignored and not queued. The requester must wait for done, or for busy = 0.
- A new req in the cycle done is high is sampled in IDLE on the next edge.
- Counter width = clog2(max(HOLD_CYCLES, GAP_CYCLES)) + 1; no wrap is possible.
- dev_uc_in is registered (driven from FSM registers); no combinational path from host_trig_* to dev_uc_in.
- The receive and transmit paths are fully independent; simultaneous activity on both has no interaction.

Decomposition:
- Shared package holds uc bus field constants: UC_TRIG_CMD_BIT=8, UC_TRIG_BYTE_LSB=0, UC_TRIG_BYTE_W=8, UC_IN_W=32, UC_OUT_W=30, plus the tx state encoding (IDLE=0, DRIVE=1, GAP=2).
- One sub-module, active_trigger_host_tx, holds the transmit FSM and counter. The receive capture logic stays in the top.

Test Plan:
- Reset: hold uc_reset low 5 cycles with dev_uc_out[8]=1 and byte 0xFF -> all outputs 0. After release with the input still high: one capture, trig_pending=0xFF, one trig_event.
- Rx sticky/overrun: device sends 0x05 held 4 cycles, then 0x04 -> trig_pending=0x05, trig_overrun=0x04, exactly two trig_event pulses. trig_clear=0x01 -> trig_pending=0x04.
- Set beats clear: capture byte 0x80 in the same cycle as trig_clear=0x80 -> trig_pending[7]=1.
- Tx nominal: pulse host_trig_req with byte 0xA3 (defaults) -> dev_uc_in=0x1A3 for exactly 4 cycles, then 0 for 2 cycles, one done pulse, busy high for 6 cycles.
- Tx rejects: req with byte 0x00 -> no activity. Req 0x11 issued while busy -> ignored, only the first byte appears on dev_uc_in.
- Reset mid-DRIVE: assert uc_reset in the 2nd DRIVE cycle -> dev_uc_in=0 and busy=0 immediately (asynchronously), no done pulse. After release, a new req transmits normally.
